// File: rtl/key_matrix_scanner.sv
// 4x8 active-low key matrix scanner with frame debounce and lowest-index priority note output.
// Define SUSTAIN_HOLD_EN to keep the last nonzero note when all keys are released.
module key_matrix_scanner #(
  parameter int SETTLE_CYCLES   = 1000,
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  rows,
  input  logic [7:0]  cols,
  output logic [31:0] note,
  output logic        note_change
);

  localparam logic [1:0] ST_SETTLE  = 2'd0;
  localparam logic [1:0] ST_SAMPLE  = 2'd1;
  localparam logic [1:0] ST_COMPARE = 2'd2;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  STABLE_MAX  = 8'(DEBOUNCE_FRAMES - 1);

  logic [1:0]  state;
  logic [1:0]  r;
  logic [15:0] settle_cnt;
  logic [7:0]  cols_s1;
  logic [7:0]  cols_s2;
  logic [31:0] frame;
  logic [31:0] prev_frame;
  logic [31:0] stable_keys;
  logic [7:0]  stable_cnt;
  logic [31:0] prio;

  // Sync flops idle high so an early sample reads "no key" rather than all-pressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      cols_s1 <= 8'hFF;
      cols_s2 <= 8'hFF;
    end else begin
      cols_s1 <= cols;
      cols_s2 <= cols_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_SETTLE;
      r           <= 2'd0;
      settle_cnt  <= 16'd0;
      frame       <= 32'd0;
      prev_frame  <= 32'd0;
      stable_cnt  <= 8'd0;
      stable_keys <= 32'd0;
    end else begin
      case (state)
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 16'd0;
            state      <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 16'd1;
          end
        end
        ST_SAMPLE: begin
          frame[{r, 3'b000} +: 8] <= ~cols_s2;
          if (r == 2'd3) begin
            state <= ST_COMPARE;
          end else begin
            r     <= r + 2'd1;
            state <= ST_SETTLE;
          end
        end
        ST_COMPARE: begin
          if (frame == prev_frame) begin
            if (stable_cnt != STABLE_MAX) stable_cnt <= stable_cnt + 8'd1;
            // Covers both the frame that reaches the limit and every saturated frame after it.
            if (stable_cnt >= STABLE_MAX - 8'd1) stable_keys <= frame;
          end else begin
            stable_cnt <= 8'd0;
            prev_frame <= frame;
          end
          r     <= 2'd0;
          state <= ST_SETTLE;
        end
        default: begin
          r     <= 2'd0;
          state <= ST_SETTLE;
        end
      endcase
    end
  end

  always_comb begin
    rows = 4'b1111;
    if (state == ST_COMPARE) rows = 4'b1110;
    else rows[r] = 1'b0;
  end

  // Walk from the highest index down so the lowest pressed key is the last to win.
  always_comb begin
    prio = 32'd0;
    for (int k = 31; k >= 0; k--) begin
      if (stable_keys[k]) prio = 32'd1 << (31 - k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      note        <= 32'd0;
      note_change <= 1'b0;
    end else begin
      note_change <= 1'b0;
`ifdef SUSTAIN_HOLD_EN
      if ((prio != note) && (prio != 32'd0)) begin
`else
      if (prio != note) begin
`endif
        note        <= prio;
        note_change <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Bench for key_matrix_scanner: directed scenarios plus random key sequences against a frame-level model.
module tb_key_matrix_scanner;

  localparam int SC = 4;
  localparam int DF = 3;
  localparam int FP = 4 * (SC + 1) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rows;
  logic [7:0]  cols;
  logic [31:0] note;
  logic        note_change;
  logic [31:0] keys = 32'd0;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] hist[$];
  logic [31:0] m_note;
  int          exp_pulses;

  always #5 clk = ~clk;

  key_matrix_scanner #(.SETTLE_CYCLES(SC), .DEBOUNCE_FRAMES(DF)) dut (
    .clk(clk),
    .rst(rst),
    .rows(rows),
    .cols(cols),
    .note(note),
    .note_change(note_change)
  );

  // Passive matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    cols = 8'hFF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 8; cc++)
        if (keys[8*rr+cc] && !rows[rr]) cols[cc] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] key_bit(input int r, input int c);
    logic [31:0] v;
    v = 32'd0;
    v[8*r+c] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] lowest_note(input logic [31:0] s);
    for (int k = 0; k < 32; k++)
      if (s[k]) return 32'h8000_0000 >> k;
    return 32'd0;
  endfunction

  // Reset leaves an all-zero reference frame, which counts as the first of the identical run.
  task automatic model_reset();
    hist.delete();
    hist.push_back(32'd0);
    m_note     = 32'd0;
    exp_pulses = 0;
  endtask

  task automatic model_frame(input logic [31:0] f);
    logic        same;
    logic [31:0] p;
    hist.push_back(f);
    if (hist.size() > DF) void'(hist.pop_front());
    exp_pulses = 0;
    same = (hist.size() == DF);
    foreach (hist[i]) if (hist[i] !== f) same = 1'b0;
    if (same) begin
      p = lowest_note(f);
`ifdef SUSTAIN_HOLD_EN
      if (p !== m_note && p !== 32'd0) begin
`else
      if (p !== m_note) begin
`endif
        m_note     = p;
        exp_pulses = 1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rows", 32'(rows), 32'h0000000E);
    check("reset_note", note, 32'd0);
    check("reset_note_change", 32'(note_change), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  // Starts in the first cycle of a frame and ends in the first cycle of the next one.
  task automatic run_frame(input logic [31:0] k);
    int          pulses;
    int          j;
    logic [3:0]  er;
    keys   = k;
    pulses = 0;
    for (int i = 0; i < FP; i++) begin
      @(posedge clk);
      #1;
      j  = i + 1;
      er = 4'b1111;
      if (j >= FP - 1) er = 4'b1110;
      else er[j/(SC+1)] = 1'b0;
      check("rows_walk", 32'(rows), 32'(er));
      if (note_change) pulses++;
      if (i == 10) check("note_model", note, m_note);
    end
    check("note_change_count", 32'(pulses), 32'(exp_pulses));
    model_frame(k);
  endtask

  task automatic run_frames(input logic [31:0] k, input int n);
    for (int i = 0; i < n; i++) run_frame(k);
  endtask

  initial begin
    logic [31:0] k12;
    logic [31:0] rk;
    int          hold;

    k12 = key_bit(1, 2);
    do_reset();

    run_frames(32'd0, 2);

    run_frames(k12, 4);
    check("single_key_note", note, 32'h0020_0000);
    run_frame(k12);

    run_frames(32'd0, 4);
    run_frames(k12, 2);
    run_frames(32'd0, 3);
`ifdef SUSTAIN_HOLD_EN
    check("bounce_note", note, 32'h0020_0000);
`else
    check("bounce_note", note, 32'd0);
`endif

    run_frames(key_bit(0, 0) | key_bit(0, 5), 4);
    check("two_keys_note", note, 32'h8000_0000);
    run_frames(key_bit(0, 5), 4);
    check("partial_release_note", note, 32'h0400_0000);

    run_frames(32'd0, 4);
`ifdef SUSTAIN_HOLD_EN
    check("release_all_note", note, 32'h0400_0000);
`else
    check("release_all_note", note, 32'd0);
`endif

    run_frames(k12, 4);
    keys = k12;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1;
    end
    check("row2_before_reset", 32'(rows), 32'h0000000B);
    do_reset();
    run_frames(k12, 3);
    check("no_note_before_reacquire", note, 32'd0);
    run_frame(k12);
    check("reacquire_note", note, 32'h0020_0000);

    for (int s = 0; s < 15; s++) begin
      rk = 32'd0;
      if ($urandom_range(0, 3) != 0) begin
        rk[$urandom_range(0, 31)] = 1'b1;
        if ($urandom_range(0, 1) == 1) rk[$urandom_range(0, 31)] = 1'b1;
      end
      hold = $urandom_range(1, 4);
      run_frames(rk, hold);
    end
    run_frames(32'd0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/key_matrix_scanner.md
KEY_MATRIX_SCANNER -- requirements
Module: key_matrix_scanner

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1000, the number of cycles a row is driven before its columns are sampled (legal range 3 to 65535).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 8, the number of consecutive identical scan frames required to accept a key state (legal range 2 to 255).
REQ-003 SHALL have port clk, input, 1 bit: system clock, the only clock in the block.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port rows, output, 4 bits: row drive, active-low.
REQ-006 SHALL have port cols, input, 8 bits: column sense, active-low, asynchronous to clk (pull-ups are external).
REQ-007 SHALL have port note, output, 32 bits: one-hot key code; bit 31 = DO4 ... bit 0 = SOL6; all-zero means no note.
REQ-008 SHALL have port note_change, output, 1 bit: single-cycle pulse asserted when note changes value.

Function
REQ-009 SHALL pass cols through a two-flop synchronizer before any use.
REQ-010 SHALL map row r, column c to key index k = 8*r + c, and key index k to note bit 31-k.
REQ-011 SHALL run a scan FSM with states SETTLE, SAMPLE and COMPARE, plus a row index r in the range 0..3.
REQ-012 In SETTLE, SHALL hold rows with only bit r low and count SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-013 In SAMPLE (1 cycle), SHALL store the inverted synchronized cols into frame bits [8r+7:8r]; if r<3, SHALL increment r and return to SETTLE; if r==3, SHALL go to COMPARE.
REQ-014 In COMPARE (1 cycle), if frame equals prev_frame, SHALL increment stable_cnt, saturating at DEBOUNCE_FRAMES-1.
REQ-015 In COMPARE, if frame differs from prev_frame, SHALL clear stable_cnt to 0 and load prev_frame with frame.
REQ-016 In COMPARE, SHALL then set r to 0 and return to SETTLE.
REQ-017 SHALL make the frame period exactly 4*(SETTLE_CYCLES+1)+1 cycles.
REQ-018 SHALL keep rows at 4'b1110 during COMPARE.
REQ-019 SHALL load stable_keys with frame in any COMPARE where stable_cnt reaches DEBOUNCE_FRAMES-1, that is, after DEBOUNCE_FRAMES identical frames in a row.
REQ-020 SHALL compute the priority result as the lowest pressed key index in stable_keys, encoded one-hot per REQ-010; simultaneous presses SHALL yield only the lowest index.
REQ-021 SHALL register note one cycle after stable_keys updates.
REQ-022 SHALL assert note_change in the same cycle that the new note value first appears, and only when that value differs from the previous value.
REQ-023 SHALL neither fire note_change nor alter note when stable_keys reloads with an unchanged priority result.

Reset
REQ-024 While rst is high at a clk edge, SHALL set: state SETTLE, r=0, settle counter 0, rows=4'b1110, frame=0, prev_frame=0, stable_cnt=0, stable_keys=0, note=0, note_change=0.
REQ-025 SHALL abandon a scan interrupted by reset; the first frame after reset SHALL start at row 0 with a full SETTLE_CYCLES period.

Configuration
REQ-026 Macro SUSTAIN_HOLD_EN SHALL control release behaviour; when defined, a priority result of all-zero SHALL leave note holding the last nonzero value with no note_change, and note SHALL return to 0 only on reset.
REQ-027 When SUSTAIN_HOLD_EN is undefined, SHALL load note=0 and pulse note_change on release of all keys.

Verification (SETTLE_CYCLES=4, DEBOUNCE_FRAMES=3, frame = 21 cycles)
REQ-028 Release rst -> rows=4'b1110, note=0, note_change=0; rows SHALL walk 1110, 1101, 1011, 0111, each held 5 cycles.
REQ-029 Hold key r=1, c=2 -> note=32'h00200000 after the 3rd identical frame, with exactly one note_change pulse.
REQ-030 Key r=0, c=0 and key r=0, c=5 pressed together -> note=32'h80000000; release c=0 only -> note=32'h04000000.
REQ-031 Key r=1, c=2 present for 2 frames, then absent (bounce) -> note stays 0 and no note_change.
REQ-032 Release all keys -> note=0 plus a pulse without SUSTAIN_HOLD_EN; note holds with no pulse with SUSTAIN_HOLD_EN.
REQ-033 Assert rst during row 2 SETTLE with a key held -> all outputs reset; note re-acquires 3 frames after rst falls.
